// File: rtl/fde_pkg.sv
// Shared definitions for the fetch-decode-execute sequencer: opcodes,
// FSM state encoding and instruction field offsets.
package fde_pkg;

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_ALU_FIRST = 4'd1;
    localparam logic [3:0] OP_ALU_LAST  = 4'd11;
    localparam logic [3:0] OP_LDI       = 4'd12;
    localparam logic [3:0] OP_JMP       = 4'd13;
    localparam logic [3:0] OP_RSVD      = 4'd14;
    localparam logic [3:0] OP_HALT      = 4'd15;

    localparam int OPC_LSB  = 12;
    localparam int DST_LSB  = 8;
    localparam int SRC1_LSB = 4;
    localparam int SRC2_LSB = 0;
    localparam int IMM_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

endpackage

// File: rtl/fde_decode.sv
// Combinational opcode classifier used by the sequencer.
module fde_decode
    import fde_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic       o_is_alu,
    output logic       o_is_ldi,
    output logic       o_is_jmp,
    output logic       o_is_halt,
    output logic       o_writes_reg
);

    assign o_is_alu     = (i_opcode >= OP_ALU_FIRST) && (i_opcode <= OP_ALU_LAST);
    assign o_is_ldi     = (i_opcode == OP_LDI);
    assign o_is_jmp     = (i_opcode == OP_JMP);
    assign o_is_halt    = (i_opcode == OP_HALT);
    assign o_writes_reg = o_is_alu || o_is_ldi;

endmodule

// File: rtl/fde_sequencer.sv
// Control FSM of the 8-bit fetch-decode-execute CPU, one instruction in flight.
// Optional FDE_SINGLE_STEP_EN adds i_step: one instruction per step, then back to IDLE.
module fde_sequencer
    import fde_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_run,
`ifdef FDE_SINGLE_STEP_EN
    input  logic              i_step,
`endif
    output logic              o_imem_req,
    output logic [PC_W-1:0]   o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [15:0]       i_imem_data,
    output logic [3:0]        o_read_reg1,
    output logic [3:0]        o_read_reg2,
    output logic [3:0]        o_alu_op,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic              o_write_en,
    output logic [3:0]        o_write_reg,
    output logic [DATA_W-1:0] o_write_data,
    output logic              o_halted,
    output logic [CNT_W-1:0]  o_retired,
    output logic [2:0]        o_dbg_state
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic is_alu, is_ldi, is_jmp, is_halt, writes_reg;
    logic start_ok;

    fde_decode u_decode (
        .i_opcode     (ir_q[OPC_LSB +: 4]),
        .o_is_alu     (is_alu),
        .o_is_ldi     (is_ldi),
        .o_is_jmp     (is_jmp),
        .o_is_halt    (is_halt),
        .o_writes_reg (writes_reg)
    );

`ifdef FDE_SINGLE_STEP_EN
    assign start_ok = i_run && i_step;
`else
    assign start_ok = i_run;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            result_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            result_q  <= result_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        result_d     = result_q;
        retired_d    = retired_q;
        o_imem_req   = 1'b0;
        o_read_reg1  = 4'd0;
        o_read_reg2  = 4'd0;
        o_alu_op     = 4'd0;
        o_write_en   = 1'b0;
        o_write_reg  = 4'd0;
        o_write_data = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) begin
                    ir_d    = i_imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                o_read_reg1 = ir_q[SRC1_LSB +: 4];
                o_read_reg2 = ir_q[SRC2_LSB +: 4];
                state_d     = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                // Read addresses stay up so the registered file output remains valid for the ALU.
                o_read_reg1 = ir_q[SRC1_LSB +: 4];
                o_read_reg2 = ir_q[SRC2_LSB +: 4];
                o_alu_op    = ir_q[OPC_LSB +: 4];
                if (is_alu)      result_d = i_alu_result;
                else if (is_ldi) result_d = DATA_W'(ir_q[IMM_LSB +: 8]);
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                o_write_en   = writes_reg && (ir_q[DST_LSB +: 4] != 4'd0);
                o_write_reg  = ir_q[DST_LSB +: 4];
                o_write_data = result_q;
                pc_d         = is_jmp ? PC_W'(ir_q[IMM_LSB +: 8]) : pc_q + PC_W'(1);
                retired_d    = retired_q + CNT_W'(1);
`ifdef FDE_SINGLE_STEP_EN
                state_d = is_halt ? ST_HALT : ST_IDLE;
`else
                if (is_halt)    state_d = ST_HALT;
                else if (i_run) state_d = ST_FETCH;
                else            state_d = ST_IDLE;
`endif
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_imem_addr = pc_q;
    assign o_halted    = (state_q == ST_HALT);
    assign o_retired   = retired_q;
    assign o_dbg_state = state_q;

endmodule
